// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 fill controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package l2_pkg;

  localparam int ADDR_W      = 16;
  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;
  localparam int LINE_IDX_W  = 11;

  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [LINE_W-1:0]     line_data_t;
  typedef logic [LINE_IDX_W-1:0] line_idx_t;

  // Fill controller sequencing: one L2 array read in flight at a time.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fill_state_e;

  // Registered fill beat presented to L1.
  typedef struct packed {
    addr_t      addr;
    line_data_t data;
  } fill_t;

  function automatic line_idx_t addr_to_line(input addr_t a);
    return a[ADDR_W-1:OFFSET_BITS];
  endfunction

  function automatic addr_t line_to_addr(input line_idx_t l);
    return {l, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_fill_ctrl_if.sv
// Bundle of L1 miss request, L2 array read and L1 fill signals.
// Latency: n/a (wiring only).
// Backpressure: req_ready throttles requests; array and fill paths have none.
interface l2_fill_ctrl_if;
  import l2_pkg::*;

  logic       req_valid;
  addr_t      req_addr;
  logic       req_ready;
  logic       arr_rd_en;
  line_idx_t  arr_rd_line;
  line_data_t arr_rd_data;
  logic       fill_valid;
  addr_t      fill_addr;
  line_data_t fill_data;
  logic       busy;

  // Environment view: L1 miss source plus the L2 array data return.
  modport master (
    output req_valid, req_addr, arr_rd_data,
    input  req_ready, arr_rd_en, arr_rd_line, fill_valid, fill_addr, fill_data, busy
  );

  // Fill controller view.
  modport slave (
    input  req_valid, req_addr, arr_rd_data,
    output req_ready, arr_rd_en, arr_rd_line, fill_valid, fill_addr, fill_data, busy
  );

endinterface

// File: rtl/l2_req_fifo.sv
// In-order queue of pending miss line indices with per-entry line compare.
// Latency: pushed entry visible at head the cycle after push.
// Backpressure: push ignored when full, pop ignored when empty.
module l2_req_fifo
  import l2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  line_idx_t        push_line,
  input  logic             pop,
  output line_idx_t        pop_line,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  input  line_idx_t        cmp_line,
  output logic [DEPTH-1:0] hit
);

  localparam int PTR_W = $clog2(DEPTH);

  line_idx_t        mem [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_line = mem[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Pointers, occupancy and per-entry valid bits; pointers wrap at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (push_ok) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are qualified by vld_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_line;
    end
  end

  // Merge lookup: the head entry stays valid through its pop cycle.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = vld_q[i] && (mem[i] == cmp_line);
    end
  end

endmodule

// File: rtl/l2_fill_ctrl.sv
// L2 fill controller: queues L1 misses, reads the L2 array, returns line fills.
// Latency: accept -> arr_rd_en +2 cycles -> fill_valid +LATENCY+1 cycles.
// Backpressure: req_ready low when queue holds FIFO_DEPTH entries; fill has none.
module l2_fill_ctrl
  import l2_pkg::*;
#(
  parameter int LATENCY    = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  l2_fill_ctrl_if.slave  io
);

  localparam int          CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  LAT_LOAD = 8'(LATENCY - 1);

  fill_state_e           state_q;
  fill_state_e           state_d;
  line_idx_t             cur_line_q;
  logic [7:0]            lat_cnt_q;
  fill_t                 fill_q;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  line_idx_t             fifo_pop_line;
  logic [FIFO_DEPTH-1:0] fifo_hit;

  line_idx_t             req_line;
  logic                  inflight_hit;
  logic                  merge_hit;
  logic                  req_accept;
  logic                  issue_rd;
  logic                  capture;

  assign req_line     = addr_to_line(io.req_addr);
  // Any non-IDLE state owns cur_line_q, including the RESP cycle.
  assign inflight_hit = (state_q != IDLE) && (cur_line_q == req_line);
  assign merge_hit    = (|fifo_hit) || inflight_hit;
  // Occupancy alone decides readiness; a same-cycle pop does not free a slot.
  assign io.req_ready = !rst && !fifo_full;
  assign req_accept   = io.req_valid && io.req_ready;
  assign fifo_push    = req_accept && !merge_hit;

  l2_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_line (req_line),
    .pop       (fifo_pop),
    .pop_line  (fifo_pop_line),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .cmp_line  (req_line),
    .hit       (fifo_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, queue pop, array strobe and data capture enable.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    issue_rd = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        issue_rd = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == 8'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ISSUE;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In-flight line, latency countdown and the registered fill beat.
  // The counter reaches zero in the cycle the array data is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_line_q <= '0;
      lat_cnt_q  <= 8'd0;
      fill_q     <= '0;
    end else begin
      if (fifo_pop) begin
        cur_line_q <= fifo_pop_line;
      end
      if (state_q == ISSUE) begin
        lat_cnt_q <= LAT_LOAD;
      end else if ((state_q == WAIT) && (lat_cnt_q != 8'd0)) begin
        lat_cnt_q <= lat_cnt_q - 8'd1;
      end
      if (capture) begin
        fill_q.addr <= line_to_addr(cur_line_q);
        fill_q.data <= io.arr_rd_data;
      end
    end
  end

  assign io.arr_rd_en   = issue_rd;
  assign io.arr_rd_line = cur_line_q;
  assign io.fill_valid  = (state_q == RESP);
  assign io.fill_addr   = fill_q.addr;
  assign io.fill_data   = fill_q.data;
  assign io.busy        = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_l2_fill_ctrl.sv
// Self-checking bench for l2_fill_ctrl: directed vectors plus a random run
// against a timeline model of request acceptance, issue and fill.
// A second instance is built with the minimum latency.
module tb_l2_fill_ctrl;
  import l2_pkg::*;

  localparam int LAT   = 40;
  localparam int DEPTH = 4;
  localparam int LAT2  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_fill_ctrl_if ifc ();
  l2_fill_ctrl_if ifc2 ();

  l2_fill_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  l2_fill_ctrl #(.LATENCY(LAT2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk (clk),
    .rst (rst),
    .io  (ifc2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic line_data_t pattern(input line_idx_t l);
    line_data_t d;
    for (int i = 0; i < 8; i++) begin
      d[i*32 +: 32] = ({21'd0, l} * 32'h9E3779B1) ^ (32'h01010101 * 32'(i + 1)) ^ 32'h5A000000;
    end
    return d;
  endfunction

  // ---------------- L2 array models: data valid exactly LATENCY cycles after strobe
  typedef struct {
    int        due;
    line_idx_t line;
  } rd_t;
  rd_t rdq[$];
  rd_t rdq2[$];

  always @(negedge clk) begin : arr_model
    line_data_t d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
    if (ifc.arr_rd_en) rdq.push_back('{cyc + LAT, ifc.arr_rd_line});
    while (rdq.size() > 0 && rdq[0].due < cyc) void'(rdq.pop_front());
    if (rdq.size() > 0 && rdq[0].due == cyc) d = pattern(rdq[0].line);
    ifc.arr_rd_data = d;
  end

  always @(negedge clk) begin : arr_model2
    line_data_t d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
    if (ifc2.arr_rd_en) rdq2.push_back('{cyc + LAT2, ifc2.arr_rd_line});
    while (rdq2.size() > 0 && rdq2[0].due < cyc) void'(rdq2.pop_front());
    if (rdq2.size() > 0 && rdq2[0].due == cyc) d = pattern(rdq2[0].line);
    ifc2.arr_rd_data = d;
  end

  // ---------------- Reference model: each queued miss is a job with timestamps
  // acc = accept cycle, iss = array strobe cycle, fil = fill cycle.
  // A line is pending (mergeable, keeps busy) from acc+1 through fil.
  typedef struct {
    line_idx_t line;
    int        acc;
    int        iss;
    int        fil;
  } job_t;
  job_t       jobs[$];
  int         last_fil = -1000;
  addr_t      m_addr   = '0;
  line_data_t m_data   = '0;

  always @(negedge clk) begin : ref_model
    int        cnt;
    bit        exp_en;
    bit        exp_fv;
    bit        exp_busy;
    bit        hit;
    line_idx_t exp_line;
    line_idx_t rl;
    job_t      j;
    if (rst) begin
      check("rst_req_ready", ifc.req_ready, 1'b0);
      jobs.delete();
      last_fil = -1000;
      m_addr   = '0;
      m_data   = '0;
    end else begin
      while (jobs.size() > 0 && jobs[0].fil < cyc) void'(jobs.pop_front());
      cnt = 0; exp_en = 0; exp_fv = 0; exp_busy = 0; exp_line = '0;
      foreach (jobs[i]) begin
        if (jobs[i].acc < cyc && cyc <= jobs[i].iss - 1) cnt++;
        if (jobs[i].acc < cyc) exp_busy = 1;
        if (jobs[i].iss == cyc) begin exp_en = 1; exp_line = jobs[i].line; end
        if (jobs[i].fil == cyc) begin
          exp_fv = 1;
          m_addr = {jobs[i].line, 5'b0};
          m_data = pattern(jobs[i].line);
        end
      end
      check("mdl_req_ready", ifc.req_ready, cnt < DEPTH);
      check("mdl_arr_rd_en", ifc.arr_rd_en, exp_en);
      if (exp_en) check("mdl_arr_rd_line", ifc.arr_rd_line, exp_line);
      check("mdl_fill_valid", ifc.fill_valid, exp_fv);
      check("mdl_fill_addr", ifc.fill_addr, m_addr);
      check("mdl_fill_data", ifc.fill_data, m_data);
      check("mdl_busy", ifc.busy, exp_busy);
      if (ifc.req_valid && cnt < DEPTH) begin
        rl  = ifc.req_addr[15:5];
        hit = 0;
        foreach (jobs[i]) if (jobs[i].line == rl) hit = 1;
        if (!hit) begin
          j.line = rl;
          j.acc  = cyc;
          j.iss  = (cyc + 2 > last_fil + 1) ? cyc + 2 : last_fil + 1;
          j.fil  = j.iss + LAT + 1;
          last_fil = j.fil;
          jobs.push_back(j);
        end
      end
    end
  end

  // ---------------- Event monitor for directed sequences
  typedef struct {
    int    c;
    addr_t a;
  } fill_rec_t;
  fill_rec_t fills[$];
  int        en_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.arr_rd_en) en_cnt++;
      if (ifc.fill_valid) fills.push_back('{cyc, ifc.fill_addr});
    end
  end

  // ---------------- Helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    ifc.req_valid  = 1'b0;
    ifc2.req_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_after", ifc.req_ready, 1'b1);
    check("rst_arr_rd_en", ifc.arr_rd_en, 1'b0);
    check("rst_arr_rd_line", ifc.arr_rd_line, 11'h000);
    check("rst_fill_addr", ifc.fill_addr, 16'h0000);
    check("rst_fill_data", ifc.fill_data, 256'h0);
    check("rst_busy", ifc.busy, 1'b0);
    step();
  endtask

  task automatic wait_out(input bit on_fill, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((on_fill && ifc.fill_valid) || (!on_fill && ifc.arr_rd_en)) begin
        at = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    addr_t     addr;
    line_idx_t line;
    addr_t     faddr;
  } vec_t;

  initial begin : main
    vec_t tbl[4];
    int   a, t, f0, e0, n;

    ifc.req_valid  = 1'b0;
    ifc.req_addr   = '0;
    ifc2.req_valid = 1'b0;
    ifc2.req_addr  = '0;

    tbl[0] = '{16'h1234, 11'h091, 16'h1220};
    tbl[1] = '{16'hFFFF, 11'h7FF, 16'hFFE0};
    tbl[2] = '{16'h0000, 11'h000, 16'h0000};
    tbl[3] = '{16'h003F, 11'h001, 16'h0020};

    // Single-miss vectors from an empty queue
    for (int k = 0; k < 4; k++) begin
      do_reset();
      a = cyc;
      ifc.req_valid = 1'b1;
      ifc.req_addr  = tbl[k].addr;
      check("tbl_ready", ifc.req_ready, 1'b1);
      step();
      ifc.req_valid = 1'b0;
      wait_out(1'b0, 10, t);
      check("tbl_issue_cycle", t, a + 2);
      check("tbl_rd_line", ifc.arr_rd_line, tbl[k].line);
      wait_out(1'b1, LAT + 10, t);
      check("tbl_fill_cycle", t, a + LAT + 3);
      check("tbl_fill_addr", ifc.fill_addr, tbl[k].faddr);
      check("tbl_fill_data", ifc.fill_data, pattern(tbl[k].line));
      @(negedge clk);
      check("tbl_fill_pulse_one", ifc.fill_valid, 1'b0);
      check("tbl_fill_addr_hold", ifc.fill_addr, tbl[k].faddr);
    end

    // Back-to-back distinct lines
    do_reset();
    f0 = fills.size();
    a  = cyc;
    for (int k = 0; k < 4; k++) begin
      ifc.req_valid = 1'b1;
      ifc.req_addr  = 16'(k * 32);
      step();
    end
    ifc.req_valid = 1'b0;
    repeat (4 * (LAT + 2) + 20) step();
    n = fills.size() - f0;
    check("b2b_fill_count", n, 4);
    if (n == 4) begin
      check("b2b_first_cycle", fills[f0].c, a + LAT + 3);
      for (int k = 0; k < 4; k++) check("b2b_order", fills[f0 + k].a, 16'(k * 32));
      for (int k = 1; k < 4; k++) check("b2b_spacing", fills[f0 + k].c - fills[f0 + k - 1].c, LAT + 2);
    end

    // Queue full while the first miss waits on the array
    do_reset();
    f0 = fills.size();
    a  = cyc;
    ifc.req_valid = 1'b1;
    ifc.req_addr  = 16'h0000;
    step();
    ifc.req_valid = 1'b0;
    repeat (4) step();
    for (int k = 1; k <= 4; k++) begin
      ifc.req_valid = 1'b1;
      ifc.req_addr  = 16'(k * 16'h0100);
      check("full_ready_fill", ifc.req_ready, 1'b1);
      step();
    end
    ifc.req_addr = 16'h0500;
    check("full_ready_low", ifc.req_ready, 1'b0);
    t = -1;
    for (int i = 0; i < LAT + 10; i++) begin
      if (ifc.req_ready) begin t = cyc; break; end
      step();
    end
    check("full_accept_after_pop", t, a + LAT + 4);
    step();
    ifc.req_valid = 1'b0;
    repeat (6 * (LAT + 2) + 20) step();
    n = fills.size() - f0;
    check("full_fill_count", n, 6);
    if (n == 6) begin
      for (int k = 0; k < 6; k++) check("full_order", fills[f0 + k].a, 16'(k * 16'h0100));
    end

    // Merge of same-line requests
    do_reset();
    f0 = fills.size();
    e0 = en_cnt;
    ifc.req_valid = 1'b1;
    ifc.req_addr  = 16'h1234;
    step();
    ifc.req_addr  = 16'h123F;
    step();
    ifc.req_addr  = 16'h1220;
    step();
    ifc.req_valid = 1'b0;
    repeat (LAT + 15) step();
    check("merge_rd_count", en_cnt - e0, 1);
    n = fills.size() - f0;
    check("merge_fill_count", n, 1);
    if (n == 1) check("merge_fill_addr", fills[f0].a, 16'h1220);

    // Reset while waiting on the array
    do_reset();
    f0 = fills.size();
    a  = cyc;
    ifc.req_valid = 1'b1;
    ifc.req_addr  = 16'h1234;
    step();
    ifc.req_valid = 1'b0;
    while (cyc < a + 20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstwait_busy", ifc.busy, 1'b0);
    step();
    repeat (LAT + 5) step();
    check("rstwait_no_fill", fills.size() - f0, 0);
    a = cyc;
    ifc.req_valid = 1'b1;
    ifc.req_addr  = 16'h0480;
    step();
    ifc.req_valid = 1'b0;
    wait_out(1'b1, LAT + 10, t);
    check("rstwait_new_latency", t, a + LAT + 3);
    check("rstwait_new_addr", ifc.fill_addr, 16'h0480);
    step();

    // Minimum-latency build
    do_reset();
    a = cyc;
    ifc2.req_valid = 1'b1;
    ifc2.req_addr  = 16'h0BEE;
    step();
    ifc2.req_valid = 1'b0;
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc2.fill_valid) begin t = cyc; break; end
    end
    check("lat2_fill_cycle", t, a + 5);
    check("lat2_fill_addr", ifc2.fill_addr, 16'h0BE0);
    check("lat2_fill_data", ifc2.fill_data, pattern(11'h05F));
    step();

    // Random traffic over a small line set, dense then sparse, rare resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i < 1500) ifc.req_valid = ($urandom_range(0, 3) == 0);
      else          ifc.req_valid = ($urandom_range(0, 29) == 0);
      ifc.req_addr = {11'(11'h3F0 + 11'($urandom_range(0, 9))), 5'($urandom_range(0, 31))};
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;
    ifc.req_valid = 1'b0;
    repeat (6 * (LAT + 2)) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/l2_fill_ctrl.md
L2_FILL_CTRL -- requirements
Module: l2_fill_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 40: cycles from arr_rd_en to arr_rd_data valid (legal 2..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: miss-request queue entries (power of two, >=2).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  L1 miss request present.
REQ-007 req_addr  input  16  L1 miss byte address.
REQ-008 req_ready  output  1  request accepted this cycle if req_valid also high.
REQ-009 arr_rd_en  output  1  one-cycle L2 array read strobe.
REQ-010 arr_rd_line  output  11  L2 line index = addr[15:5].
REQ-011 arr_rd_data  input  256  L2 line data, valid exactly LATENCY cycles after arr_rd_en.
REQ-012 fill_valid  output  1  one-cycle fill pulse to L1, no backpressure.
REQ-013 fill_addr  output  16  line-aligned fill address (bits [4:0] = 0).
REQ-014 fill_data  output  256  fill line data.
REQ-015 busy  output  1  high while FIFO non-empty or FSM not IDLE.

Function
REQ-016 SHALL accept a request on req_valid && req_ready; req_ready = (count < FIFO_DEPTH), count-based only (full rejects even with same-cycle pop).
REQ-017 SHALL merge a request whose addr[15:5] equals any valid FIFO entry or the in-flight line: accepted (req_ready honoured) but not enqueued, no extra fill.
REQ-018 SHALL store line index only; FIFO strictly in order; pointers wrap modulo FIFO_DEPTH.
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; IDLE->ISSUE when FIFO non-empty (pop, latch line); ISSUE->WAIT unconditionally; WAIT->RESP when latency counter expires; RESP->ISSUE if FIFO non-empty (pop) else IDLE.
REQ-020 arr_rd_en SHALL be high only in ISSUE, exactly one cycle per popped request, arr_rd_line = latched line.
REQ-021 With arr_rd_en in cycle T, SHALL register arr_rd_data at end of cycle T+LATENCY and assert fill_valid in cycle T+LATENCY+1 (RESP).
REQ-022 fill_addr SHALL equal {line,5'b0}; fill_addr/fill_data hold last fill value when fill_valid low.
REQ-023 Empty-queue latency: request accepted cycle A -> arr_rd_en cycle A+2 -> fill_valid cycle A+LATENCY+3.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; merge check SHALL include the entry popped that cycle (now in-flight).
REQ-025 At most one request in flight; latency counter width 8 bits, no wrap.

Reset
REQ-026 On rst: FSM IDLE, FIFO empty, pointers/count 0, counter 0, in-flight line discarded.
REQ-027 Reset values: req_ready 0 during rst cycle then 1, arr_rd_en 0, arr_rd_line 0, fill_valid 0, fill_addr 0, fill_data 0, busy 0.
REQ-028 rst mid-WAIT SHALL suppress the pending fill; arr_rd_data arriving later SHALL be ignored.

Structure
REQ-029 Shared package l2_pkg SHALL hold ADDR_W=16, LINE_W=256, OFFSET_BITS=5, LINE_IDX_W=11 and the FSM state enum.
REQ-030 Request queue SHALL be sub-module l2_req_fifo (push/pop/full/empty/count plus per-entry line compare outputs for merge).

Verification
REQ-031 Single miss: req 0x1234 at cycle 10 -> arr_rd_en cycle 12, arr_rd_line 0x091, fill_valid cycle 53, fill_addr 0x1220, fill_data = driven pattern.
REQ-032 Back-to-back: 0x0000,0x0020,0x0040,0x0060 in consecutive cycles -> four fills in order, 42-cycle spacing, no drop.
REQ-033 Full: 5 distinct lines while first in WAIT -> req_ready low when count=4, 6th accepted after next pop.
REQ-034 Merge: 0x1234 then 0x123F and 0x1220 -> exactly one arr_rd_en, one fill 0x1220.
REQ-035 Reset mid-WAIT at cycle 30 of single miss -> no fill_valid, busy 0 next cycle, new request completes with LATENCY+3 latency.
REQ-036 LATENCY=2 build: single miss -> fill_valid exactly 5 cycles after acceptance.
